// File: rtl/dnn_sched.sv
// Issue controller and result FIFO for the fixed-latency 4-4-2 DNN datapath.
// Issues a vector only when a FIFO slot is reserved for its result, so the non-stalling pipe never drops one.
module dnn_sched #(
    parameter int I_W   = 7,
    parameter int LAT   = 6,
    parameter int DEPTH = 16,
    localparam int O_W  = I_W + 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [4*I_W-1:0] s_x,
    output logic [4*I_W-1:0] dp_x,
    output logic             dp_in_ready,
    input  logic [O_W-1:0]   dp_out0,
    input  logic [O_W-1:0]   dp_out1,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [O_W-1:0]   m_out0,
    output logic [O_W-1:0]   m_out1,
    output logic             busy,
    output logic [15:0]      res_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [LAT-1:0] vpipe;
    logic [CW-1:0]  fifo_cnt;
    logic [CW-1:0]  inflight;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [2*O_W-1:0] mem [DEPTH];
    logic           credit, accept, push, pop;

    // Credit uses registered occupancy only; a same-cycle pop frees its slot one cycle later.
    assign credit  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign s_ready = (state == RUN) && credit;
    assign accept  = s_valid && s_ready;
    assign push    = vpipe[LAT-1];
    assign m_valid = (fifo_cnt != '0);
    assign pop     = m_valid && m_ready;
    assign {m_out0, m_out1} = mem[rd_ptr];
    assign busy    = (state != IDLE) || (inflight != '0) || m_valid;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dp_x        <= '0;
            dp_in_ready <= 1'b0;
            vpipe       <= '0;
            inflight    <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            res_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            dp_in_ready <= accept;
            if (accept) dp_x <= s_x;
            // Shift toward the push end; the token leaving vpipe[LAT-1] is the one being pushed now.
            vpipe <= LAT'({vpipe, dp_in_ready});

            unique case ({accept, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                res_cnt <= res_cnt + 1'b1;
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {dp_out0, dp_out1};
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_cnt != CW'(DEPTH)));

endmodule
